add_sched: RTL

ADD_SCHED -- requirements
Module: add_sched

---
 rtl/add_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/add_sched.sv
// add_sched: round-robin scheduler that shares one 2-cycle-latency adder
// between N requesters and routes each sum back to its owner.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   req[N]             per-requester request, held until granted
//   req_a/req_b[N*W]   operands, slice i*W +: W belongs to requester i
//   en_mask[N]         per-requester enable (0 = ineligible)
//   gnt[N]             combinational one-hot/zero grant (accept strobe)
//   op_start/op_a/op_b registered issue to the shared adder
//   op_y/op_valid      adder sum and result strobe (2 cycles after op_start)
//   rsp_valid/rsp_id/rsp_data  registered one-cycle response
//   busy               high while any accepted operation is still in flight
//   err                sticky protocol error (op_valid/tag disagreement)
module add_sched #(
  parameter int unsigned W  = 12,
  parameter int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  req_a,
  input  logic [N*W-1:0]  req_b,
  input  logic [N-1:0]    en_mask,
  output logic [N-1:0]    gnt,
  output logic            op_start,
  output logic [W-1:0]    op_a,
  output logic [W-1:0]    op_b,
  input  logic [W-1:0]    op_y,
  input  logic            op_valid,
  output logic            rsp_valid,
  output logic [IW-1:0]   rsp_id,
  output logic [W-1:0]    rsp_data,
  output logic            busy,
  output logic            err
);

  localparam int unsigned TAG_STAGES = 3;
  localparam int unsigned IGN_CYCLES = 2;

  // Requester tag riding alongside the adder latency.
  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
  } tag_t;

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [N-1:0]  elig;
  logic [IW-1:0] cand;
  logic [IW-1:0] gnt_id;
  logic          gnt_any;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  tag_t          tag [TAG_STAGES];
  logic [1:0]    ign_cnt;
  logic          ign_active;
  logic          head_v;
  logic          rsp_fire;
  logic          mismatch;
  logic          busy_nxt;

  // Round-robin search starting at ptr; nothing is eligible during reset.
  always_comb begin
    elig    = req & en_mask & {N{~rst}};
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!gnt_any && elig[cand]) begin
        gnt_any    = 1'b1;
        gnt_id     = cand;
        gnt[cand]  = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner, wrapping at N-1.
  always_comb begin
    ptr_nxt = ptr;
    if (gnt_any) begin
      ptr_nxt = (32'(gnt_id) == N - 1) ? '0 : gnt_id + IW'(1);
    end
  end

  assign sel_a = req_a[32'(gnt_id) * W +: W];
  assign sel_b = req_b[32'(gnt_id) * W +: W];

  // Head tag must agree with op_valid, except in the post-reset window where
  // the adder may still emit stale strobes.
  assign head_v     = tag[TAG_STAGES-1].v;
  assign ign_active = (ign_cnt != 2'd0);
  assign rsp_fire   = op_valid & head_v;
  assign mismatch   = ~ign_active & (op_valid != head_v);

  // busy tracks the next values of op_start, the tag valids and rsp_valid.
  assign busy_nxt = gnt_any | tag[0].v | tag[1].v | rsp_fire;

  // Issue, tag pipeline, response and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      op_start  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      for (int unsigned s = 0; s < TAG_STAGES; s++) begin
        tag[s] <= '0;
      end
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      ign_cnt   <= 2'(IGN_CYCLES);
    end else begin
      ptr      <= ptr_nxt;
      op_start <= gnt_any;
      if (gnt_any) begin
        op_a <= sel_a;
        op_b <= sel_b;
      end
      tag[0].v  <= gnt_any;
      tag[0].id <= gnt_id;
      for (int unsigned s = 1; s < TAG_STAGES; s++) begin
        tag[s] <= tag[s-1];
      end
      rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        rsp_id   <= tag[TAG_STAGES-1].id;
        rsp_data <= op_y;
      end
      err  <= err | mismatch;
      busy <= busy_nxt;
      if (ign_active) begin
        ign_cnt <= ign_cnt - 2'd1;
      end
    end
  end

endmodule
